srp_bram_correlator: RTL
========================

Name: srp_bram_correlator

Overview:
- Downstream consumer of the time-synchronizer sample buffer BRAM (single-port, 32-bit words, 12-bit address, depth 2097, one-cycle read latency).
- On start, reads a ring-buffered window and computes a sliding correlation against a Shapiro-Rudin ±1 preamble over NUM_LAGS lags.
- Reports the lag with maximum signed correlation, which the frame sync logic uses as the timing estimate.
- Read-only master of the BRAM port.

Parameters:
- ADDR_W, 12, BRAM address width.
- DATA_W, 32, sample width; samples are unsigned.
- BUF_DEPTH, 2097, ring buffer depth; addresses wrap modulo BUF_DEPTH.
- SEQ_LEN, 64, preamble length in chips; must be a power of 2 and at least 2.
- NUM_LAGS, 2048, number of lags evaluated; must be at least 1.
- ACC_W, 40, signed accumulator width; must be at least DATA_W+log2(SEQ_LEN)+1.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a search; sampled only in IDLE.
- base_addr  in  ADDR_W  buffer address of lag 0; must be < BUF_DEPTH.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable; constant 0.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_dout  in  DATA_W  BRAM read data, valid one cycle after the enabled address.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when results update.
- peak_lag  out  ADDR_W  lag index (0..NUM_LAGS-1) of the maximum.
- peak_val  out  ACC_W  signed correlation value at peak_lag.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulator and best registers 0.
- Preamble chip: s(i)=+1 if popcount(i & (i>>1)) is even, else -1. For SEQ_LEN=8 this gives + + + - + + - +.
- Correlation: C(k) = sum over i=0..SEQ_LEN-1 of s(i)*RAM[(base_addr+k+i) mod BUF_DEPTH]. Data is zero-extended to ACC_W, then added or subtracted.
- FSM states:
  - IDLE: start=1 latches base_addr, sets k=0, and moves to RUN.
  - RUN: SEQ_LEN cycles. Issues one address per cycle with bram_en=1. Data returned for chip i-1 is accumulated in the same cycle.
  - DRAIN: 1 cycle. bram_en=0; the last sample is accumulated.
  - CMP: 1 cycle.
    - k=0: C(0) loads the best registers unconditionally.
    - k>0: replace best only if C(k) > best (strictly greater, so the earliest lag wins ties).
    - Clears the accumulator. If k=NUM_LAGS-1, go to DONE; else k++ and return to RUN.
  - DONE: 1 cycle. done=1; peak_lag and peak_val register the best values; next state IDLE.
- Latency: start is sampled at cycle 0; done is high in cycle NUM_LAGS*(SEQ_LEN+2)+1.
- Address pointer: the lag start pointer and chip pointer increment and wrap BUF_DEPTH-1 -> 0. No modulo divider is used.
- start while busy is ignored. start in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- peak_lag and peak_val hold their values between done pulses, including through a new search.
- rst mid-search: next cycle is IDLE; bram_en, busy, done are 0; peak outputs are 0. Any pending read data is discarded.
- bram_en is low in IDLE, DRAIN, CMP and DONE. bram_we is never 1.

Decomposition:
- Package srp_corr_pkg holds:
  - state enum (IDLE, RUN, DRAIN, CMP, DONE);
  - function srp_chip(i) returning the sign bit;
  - default parameter constants.
- No sub-module: address wrap counters and the accumulator are small enough to stay inline.

Test Plan:
- Test parameters for all scenarios: SEQ_LEN=8, NUM_LAGS=16, BUF_DEPTH=32, behavioural 1-cycle BRAM model.
- Pattern match: RAM[5+i]=1000 where s(i)=+1 and 0 where s(i)=-1, all other words 0, base_addr=0 -> peak_lag=5, peak_val=6000.
- All-zero RAM, base_addr=0 -> peak_lag=0, peak_val=0 (tie resolves to earliest lag).
- Ring wrap: same pattern written at physical addresses 30,31,0..5, base_addr=28 -> peak_lag=2, peak_val=6000. bram_addr sequence shows 31->0.
- Latency and handshake: check done pulse in cycle 161, exactly 1 cycle wide.
  - busy is high in cycles 1..161.
  - bram_en is high exactly 128 cycles; bram_we is never 1.
  - start pulsed at cycle 50 has no effect.
- Reset mid-op: assert rst at cycle 70 -> cycle 71 shows IDLE, all outputs 0. A new start then completes normally with the expected peak.
- Negative correlation: RAM[i]=1000 where s(i)=-1 at lags 0..7, zeros elsewhere -> peak_val >= 0 and is not at lag 0. Check against a golden model.

Source files
------------

// File: rtl/srp_corr_pkg.sv
// Shared types, defaults and the Shapiro-Rudin chip rule for the BRAM correlator.
package srp_corr_pkg;

  localparam int SRP_ADDR_W    = 12;
  localparam int SRP_DATA_W    = 32;
  localparam int SRP_BUF_DEPTH = 2097;
  localparam int SRP_SEQ_LEN   = 64;
  localparam int SRP_NUM_LAGS  = 2048;
  localparam int SRP_ACC_W     = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CMP,
    S_DONE
  } srp_state_e;

  // Sign bit of chip idx: 1 means -1, 0 means +1 (odd popcount of idx & (idx>>1)).
  function automatic logic srp_chip(input logic [31:0] idx);
    return ^(idx & (idx >> 1));
  endfunction

endpackage

// File: rtl/srp_bram_correlator.sv
// Sliding Shapiro-Rudin correlation over a ring-buffered BRAM window; reports
// the earliest lag holding the maximum signed correlation.
module srp_bram_correlator
  import srp_corr_pkg::*;
#(
  parameter int ADDR_W    = SRP_ADDR_W,
  parameter int DATA_W    = SRP_DATA_W,
  parameter int BUF_DEPTH = SRP_BUF_DEPTH,
  parameter int SEQ_LEN   = SRP_SEQ_LEN,
  parameter int NUM_LAGS  = SRP_NUM_LAGS,
  parameter int ACC_W     = SRP_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    bram_en,
  output logic                    bram_we,
  output logic [ADDR_W-1:0]       bram_addr,
  input  logic [DATA_W-1:0]       bram_dout,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       peak_lag,
  output logic signed [ACC_W-1:0] peak_val
);

  localparam int LAG_W  = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;
  localparam int CHIP_W = $clog2(SEQ_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  srp_state_e               state_q;
  logic [ADDR_W-1:0]        lag_ptr_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [CHIP_W-1:0]        chip_q;
  logic [LAG_W-1:0]         lag_q;
  logic                     en_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     pend_q;
  logic                     neg_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  best_val_q;
  logic [LAG_W-1:0]         best_lag_q;
  logic [ADDR_W-1:0]        peak_lag_q;
  logic signed [ACC_W-1:0]  peak_val_q;

  logic signed [ACC_W-1:0]  samp;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  best_val_d;
  logic [LAG_W-1:0]         best_lag_d;
  logic                     last_chip;
  logic                     last_lag;
  logic                     take_best;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    samp       = $signed({{(ACC_W - DATA_W){1'b0}}, bram_dout});
    acc_d      = acc_q;
    if (pend_q) acc_d = neg_q ? (acc_q - samp) : (acc_q + samp);
    last_chip  = (chip_q == CHIP_W'(SEQ_LEN - 1));
    last_lag   = (lag_q == LAG_W'(NUM_LAGS - 1));
    // Strict compare keeps the earliest lag on ties; lag 0 always seeds the best.
    take_best  = (lag_q == '0) || (acc_q > best_val_q);
    best_val_d = take_best ? acc_q : best_val_q;
    best_lag_d = take_best ? lag_q : best_lag_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lag_ptr_q  <= '0;
      addr_q     <= '0;
      chip_q     <= '0;
      lag_q      <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      best_val_q <= '0;
      best_lag_q <= '0;
      peak_lag_q <= '0;
      peak_val_q <= '0;
    end else begin
      // Data for the address issued this cycle arrives next cycle with this sign.
      pend_q <= en_q;
      neg_q  <= srp_chip(32'(chip_q));
      acc_q  <= acc_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            lag_ptr_q <= base_addr;
            addr_q    <= base_addr;
            chip_q    <= '0;
            lag_q     <= '0;
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (last_chip) begin
            en_q    <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            addr_q <= wrap_inc(addr_q);
            chip_q <= chip_q + 1'b1;
          end
        end
        S_DRAIN: state_q <= S_CMP;
        S_CMP: begin
          best_val_q <= best_val_d;
          best_lag_q <= best_lag_d;
          acc_q      <= '0;
          if (last_lag) begin
            done_q     <= 1'b1;
            peak_lag_q <= ADDR_W'(best_lag_d);
            peak_val_q <= best_val_d;
            state_q    <= S_DONE;
          end else begin
            lag_q     <= lag_q + 1'b1;
            lag_ptr_q <= wrap_inc(lag_ptr_q);
            addr_q    <= wrap_inc(lag_ptr_q);
            chip_q    <= '0;
            en_q      <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bram_en   = en_q;
  assign bram_we   = 1'b0;
  assign bram_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign peak_lag  = peak_lag_q;
  assign peak_val  = peak_val_q;

endmodule
